lgn_stream_driver: RTL and testbench
====================================

# lgn_stream_driver

Host-side transmitter for the LGN classifier core's byte-stream input. Accepts one full 256-bit binarised image over a valid/ready handshake. Serialises it MSB-byte-first onto the core's 8-bit input bus, one byte per clock, so the core's free-running shift register holds exactly the image. After a fixed core latency it samples the core's 15-bit popcount score and returns it on a second valid/ready handshake.

## Interface
- `INPUTS`, 256, image width in bits; must be a multiple of `BUS_W`.
- `BUS_W`, 8, bytes-bus width to core.
- `SUM_W`, 15, score width from core.
- `LAT`, 1, edges after last-byte capture at which `sum_in` is sampled; legal range 1..15.

Ports:
- `clk`  in  1  sole clock.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `img_valid`  in  1  image offered.
- `img_ready`  out  1  driver can accept image.
- `img_data`  in  `INPUTS`  image; bits [INPUTS-1 -: 8] are sent first.
- `bus_out`  out  `BUS_W`  registered byte to core input bus.
- `sum_in`  in  `SUM_W`  core score (combinational from core shift register).
- `res_valid`  out  1  score available.
- `res_ready`  in  1  consumer takes score.
- `res_sum`  out  `SUM_W`  captured score.
- `busy`  out  1  high in any state other than IDLE.

## Operation
- States: IDLE, SEND, WAIT, RESULT.
- IDLE: `img_ready`=1. On `img_valid`&&`img_ready`, latch `img_data` into a local shift register, drive byte 0 (top byte) on `bus_out`, clear beat counter, then go to SEND.
- SEND: each edge advances one byte. After byte `INPUTS/BUS_W-1` (byte 31 at defaults) is driven, `bus_out` returns to 0 and the FSM goes to WAIT. Beat counter width is `$clog2(INPUTS/BUS_W)`.
- WAIT: count `LAT` edges after the core captures the last byte. On the final one, register `sum_in` into `res_sum` and go to RESULT.
- RESULT: `res_valid`=1 and `res_sum` stable until `res_valid`&&`res_ready`, then go to IDLE. `img_ready` stays 0 until back in IDLE; there is no overlap of images.
- `bus_out` is 0 in every state except SEND.
- The core shifts every clock with no enable. Bytes after the image (zeros) displace it after `LAT` edges, so `LAT` must match the core's score latency exactly.
- Reset values: `img_ready`=0 while `rst_n` low, 1 after; `bus_out`=0; `res_valid`=0; `res_sum`=0; `busy`=0; state IDLE. Reset mid-SEND/WAIT/RESULT aborts immediately and drops any pending result.

## Timing
- Accept edge E0. Byte k is on `bus_out` between E(k) and E(k+1), and the core captures it at E(k+1).
- At defaults the core holds the full image after E32. `sum_in` is sampled at E(32+LAT) = E33, and `res_valid` is high from E33.
- Accept-to-result latency is `INPUTS/BUS_W + LAT` edges.
- If `res_ready` is already high when `res_valid` rises, the handshake completes on the next edge. `img_ready` is then high one cycle later, so sustained throughput is one image per `INPUTS/BUS_W + LAT + 2` cycles.
- `img_valid` while not in IDLE is ignored; the offered `img_data` is not sampled.

## Configuration
- `LGN_DRV_MAXTRACK_EN` defined: adds ports `max_clr` (in, 1), `max_sum` (out, `SUM_W`), `max_idx` (out, 8).
  - An 8-bit result counter increments on each capture and wraps from 255 to 0.
  - On capture, if `sum_in` > `max_sum` (strict; ties keep the earlier result), update `max_sum` and `max_idx`.
  - `max_clr` synchronously zeroes all three registers and takes priority over a same-edge capture.
  - Reset zeroes all three.
- Undefined: those ports and registers are absent; all other behaviour is identical.

## Structure
- Shared package `lgn_pkg`: `INPUTS`, `BUS_W`, `SUM_W` constants and the `drv_state_t` enum (IDLE, SEND, WAIT, RESULT).
- One sub-module, `lgn_max_tracker`, instantiated only under `LGN_DRV_MAXTRACK_EN`.

## Test plan
- Image 0x0102…1F20 (bytes 1..32), `LAT`=1, behavioural model of the core's shift register → `bus_out` shows 0x01..0x20 on E0..E31; model register equals image after E32; `res_valid` rises at E33 with `res_sum` = model popcount.
- All-ones image, model score = 256 → `res_sum`=256. Hold `res_ready`=0 for 10 cycles → `res_sum` stable and `img_ready`=0 throughout.
- `img_valid` pulsed during SEND with a different image → ignored; result matches the first image.
- `rst_n` asserted at E15 → `bus_out`=0, `res_valid`=0, `busy`=0 immediately. A new image after release completes normally.
- `LAT`=3 with a core model using a 2-stage registered score → correct score captured at E35.
- With `LGN_DRV_MAXTRACK_EN`, scores 100, 250, 250, 30 → `max_sum`=250, `max_idx`=1. `max_clr` issued on the capture edge of a 300 score → all three zeroed.

Source files
------------

// File: rtl/lgn_pkg.sv
// Shared constants and driver state encoding
// for the LGN classifier stream driver.
package lgn_pkg;

  localparam int INPUTS = 256;
  localparam int BUS_W  = 8;
  localparam int SUM_W  = 15;

  typedef enum logic [1:0] {
    IDLE,
    SEND,
    WAIT,
    RESULT
  } drv_state_t;

endpackage

// File: rtl/lgn_max_tracker.sv
// Running maximum of captured scores and the
// index of the result that produced it.
module lgn_max_tracker #(
  parameter int SUM_W = 15
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cap,
  input  logic [SUM_W-1:0] sum_in,
  input  logic             max_clr,
  output logic [SUM_W-1:0] max_sum,
  output logic [7:0]       max_idx
);

  logic [7:0] res_cnt;

  // strict compare: ties keep the earlier index
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_cnt <= '0;
      max_sum <= '0;
      max_idx <= '0;
    end else if (max_clr) begin
      res_cnt <= '0;
      max_sum <= '0;
      max_idx <= '0;
    end else if (cap) begin
      res_cnt <= res_cnt + 8'd1;
      if (sum_in > max_sum) begin
        max_sum <= sum_in;
        max_idx <= res_cnt;
      end
    end
  end

endmodule

// File: rtl/lgn_stream_driver.sv
// Image serialiser and score collector for the LGN core.
// Optional max tracking: define LGN_DRV_MAXTRACK_EN.
module lgn_stream_driver #(
  parameter int INPUTS = lgn_pkg::INPUTS,
  parameter int BUS_W  = lgn_pkg::BUS_W,
  parameter int SUM_W  = lgn_pkg::SUM_W,
  parameter int LAT    = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              img_valid,
  output logic              img_ready,
  input  logic [INPUTS-1:0] img_data,
  output logic [BUS_W-1:0]  bus_out,
  input  logic [SUM_W-1:0]  sum_in,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [SUM_W-1:0]  res_sum,
`ifdef LGN_DRV_MAXTRACK_EN
  input  logic              max_clr,
  output logic [SUM_W-1:0]  max_sum,
  output logic [7:0]        max_idx,
`endif
  output logic              busy
);

  import lgn_pkg::*;

  localparam int NBEAT = INPUTS / BUS_W;
  localparam int BW = (NBEAT > 1) ? $clog2(NBEAT) : 1;

  drv_state_t state, state_nx;

  logic [INPUTS-1:0] sreg;
  logic [BW-1:0]     beat;
  logic [3:0]        wcnt;
  logic              last_beat;
  logic              last_wait;
  logic              accept;
  logic              cap;

  assign last_beat = (beat == BW'(NBEAT - 1));
  assign last_wait = (wcnt == 4'(LAT - 1));

  assign img_ready = (state == IDLE) && rst_n;
  assign res_valid = (state == RESULT);
  assign busy      = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    accept   = 1'b0;
    cap      = 1'b0;
    unique case (1'b1)
      state == IDLE: begin
        if (img_valid) begin
          accept   = 1'b1;
          state_nx = SEND;
        end
      end
      state == SEND: begin
        if (last_beat) state_nx = WAIT;
      end
      state == WAIT: begin
        if (last_wait) begin
          cap      = 1'b1;
          state_nx = RESULT;
        end
      end
      state == RESULT: begin
        if (res_ready) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // top byte goes out on the accept edge itself
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sreg    <= '0;
      beat    <= '0;
      wcnt    <= '0;
      bus_out <= '0;
      res_sum <= '0;
    end else begin
      if (accept) begin
        bus_out <= img_data[INPUTS-1 -: BUS_W];
        sreg    <= img_data << BUS_W;
        beat    <= '0;
      end else if (state == SEND) begin
        if (last_beat) begin
          bus_out <= '0;
          wcnt    <= '0;
        end else begin
          bus_out <= sreg[INPUTS-1 -: BUS_W];
          sreg    <= sreg << BUS_W;
          beat    <= beat + 1'b1;
        end
      end else if (state == WAIT && !last_wait) begin
        wcnt <= wcnt + 4'd1;
      end
      if (cap) res_sum <= sum_in;
    end
  end

`ifdef LGN_DRV_MAXTRACK_EN
  lgn_max_tracker #(
    .SUM_W(SUM_W)
  ) u_max (
    .clk    (clk),
    .rst_n  (rst_n),
    .cap    (cap),
    .sum_in (sum_in),
    .max_clr(max_clr),
    .max_sum(max_sum),
    .max_idx(max_idx)
  );
`endif

endmodule

// File: tb/tb_lgn_stream_driver.sv
// Bench for lgn_stream_driver: LAT=1 and LAT=3
// instances driving behavioural core models.
module tb_lgn_stream_driver;

  localparam int N  = 256;
  localparam int B  = 8;
  localparam int S  = 15;
  localparam int NB = N / B;

  logic clk = 0;
  logic rst_n = 0;
  always #5 clk = ~clk;

  logic         img_valid = 0, res_ready = 0;
  logic [N-1:0] img_data = '0;
  logic         img_ready, res_valid, busy;
  logic [B-1:0] bus_out;
  logic [S-1:0] sum_in, res_sum;
  logic         max_clr = 0;
  logic [S-1:0] max_sum;
  logic [7:0]   max_idx;

  logic         img_valid3 = 0, res_ready3 = 0;
  logic [N-1:0] img_data3 = '0;
  logic         img_ready3, res_valid3, busy3;
  logic [B-1:0] bus3;
  logic [S-1:0] sum3, res_sum3;
  logic [S-1:0] max_sum3;
  logic [7:0]   max_idx3;

  logic         ovr_en = 0;
  logic [S-1:0] ovr_val = '0;

  int errs = 0;
  int checks = 0;

  // core models: free-running byte shift registers
  logic [N-1:0] core1, core3;
  logic [S-1:0] s3a, s3b;
  always @(posedge clk) core1 <= {core1[N-B-1:0], bus_out};
  assign sum_in = ovr_en ? ovr_val : S'($countones(core1));
  always @(posedge clk) begin
    core3 <= {core3[N-B-1:0], bus3};
    s3a   <= S'($countones(core3));
    s3b   <= s3a;
  end
  assign sum3 = s3b;

  lgn_stream_driver #(.LAT(1)) dut (
    .clk(clk), .rst_n(rst_n),
    .img_valid(img_valid), .img_ready(img_ready),
    .img_data(img_data), .bus_out(bus_out),
    .sum_in(sum_in), .res_valid(res_valid),
    .res_ready(res_ready), .res_sum(res_sum),
`ifdef LGN_DRV_MAXTRACK_EN
    .max_clr(max_clr), .max_sum(max_sum),
    .max_idx(max_idx),
`endif
    .busy(busy)
  );

  lgn_stream_driver #(.LAT(3)) dut3 (
    .clk(clk), .rst_n(rst_n),
    .img_valid(img_valid3), .img_ready(img_ready3),
    .img_data(img_data3), .bus_out(bus3),
    .sum_in(sum3), .res_valid(res_valid3),
    .res_ready(res_ready3), .res_sum(res_sum3),
`ifdef LGN_DRV_MAXTRACK_EN
    .max_clr(1'b0), .max_sum(max_sum3),
    .max_idx(max_idx3),
`endif
    .busy(busy3)
  );

  function automatic logic [N-1:0] ones(input int n);
    logic [N-1:0] m;
    m = '0;
    for (int i = 0; i < n; i++) m[i] = 1'b1;
    return m;
  endfunction

  function automatic logic [N-1:0] rnd_img();
    logic [N-1:0] m;
    for (int i = 0; i < N / 32; i++) m[i*32 +: 32] = $urandom;
    return m;
  endfunction

  task automatic run1(input logic [N-1:0] img, input int hold,
                      input bit poke, input bit clr);
    logic [S-1:0] exp;
    logic [B-1:0] eb;
    int n;
    exp = ovr_en ? ovr_val : S'($countones(img));
    n = 0;
    while (!img_ready && n < 100) begin
      @(posedge clk); #1; n++;
    end
    checks++;
    if (img_ready !== 1'b1) begin
      errs++; $display("FAIL ready_wait got=%b want=1", img_ready);
    end
    res_ready = (hold == 0);
    img_data = img; img_valid = 1;
    @(posedge clk); #1;
    img_valid = 0;
    for (int k = 0; k < NB; k++) begin
      eb = img[N-1-B*k -: B];
      checks++;
      if (bus_out !== eb) begin
        errs++; $display("FAIL bus_byte%0d got=%h want=%h", k, bus_out, eb);
      end
      checks++;
      if (busy !== 1'b1 || img_ready !== 1'b0) begin
        errs++; $display("FAIL send_flags%0d busy=%b rdy=%b want 1/0", k, busy, img_ready);
      end
      if (poke && k == 4) begin img_valid = 1; img_data = ~img; end
      if (poke && k == 8) img_valid = 0;
      @(posedge clk); #1;
    end
    checks++;
    if (core1 !== img) begin
      errs++; $display("FAIL core_image got=%h want=%h", core1, img);
    end
    checks++;
    if (bus_out !== '0 || res_valid !== 1'b0) begin
      errs++; $display("FAIL e32 bus=%h rv=%b want 0/0", bus_out, res_valid);
    end
    if (clr) max_clr = 1;
    @(posedge clk); #1;
    max_clr = 0;
    checks++;
    if (res_valid !== 1'b1 || res_sum !== exp) begin
      errs++; $display("FAIL result rv=%b sum=%0d want 1/%0d", res_valid, res_sum, exp);
    end
    for (int h = 0; h < hold; h++) begin
      @(posedge clk); #1;
      checks++;
      if (res_valid !== 1'b1 || res_sum !== exp || img_ready !== 1'b0) begin
        errs++; $display("FAIL hold%0d rv=%b sum=%0d rdy=%b want 1/%0d/0", h, res_valid, res_sum, img_ready, exp);
      end
    end
    res_ready = 1;
    @(posedge clk); #1;
    res_ready = 0;
    checks++;
    if (res_valid !== 1'b0 || img_ready !== 1'b1 || busy !== 1'b0) begin
      errs++; $display("FAIL handshake rv=%b rdy=%b busy=%b want 0/1/0", res_valid, img_ready, busy);
    end
  endtask

  task automatic test_reset();
    #1;
    checks++;
    if (img_ready !== 0 || bus_out !== '0 || res_valid !== 0 ||
        res_sum !== '0 || busy !== 0) begin
      errs++; $display("FAIL reset_vals rdy=%b bus=%h rv=%b sum=%0d busy=%b want all 0", img_ready, bus_out, res_valid, res_sum, busy);
    end
    @(posedge clk); #1; rst_n = 1; #1;
    checks++;
    if (img_ready !== 1'b1) begin
      errs++; $display("FAIL ready_after_reset got=%b want=1", img_ready);
    end
  endtask

  task automatic test_counting();
    logic [N-1:0] img;
    for (int k = 0; k < NB; k++) img[N-1-B*k -: B] = B'(k + 1);
    run1(img, 0, 0, 0);
  endtask

  task automatic test_all_ones_hold();
    run1({N{1'b1}}, 10, 0, 0);
  endtask

  task automatic test_ignore_valid();
    run1(rnd_img(), 0, 1, 0);
  endtask

  task automatic test_mid_reset();
    img_data = rnd_img(); img_valid = 1;
    @(posedge clk); #1;
    img_valid = 0;
    repeat (15) @(posedge clk);
    #1; rst_n = 0; #1;
    checks++;
    if (bus_out !== '0 || res_valid !== 0 || busy !== 0 || img_ready !== 0) begin
      errs++; $display("FAIL mid_reset bus=%h rv=%b busy=%b rdy=%b want 0", bus_out, res_valid, busy, img_ready);
    end
    @(posedge clk); #1; rst_n = 1;
    run1(rnd_img(), 1, 0, 0);
  endtask

  task automatic test_lat3();
    logic [N-1:0] img;
    int n;
    img = rnd_img();
    img_data3 = img; img_valid3 = 1; res_ready3 = 1;
    @(posedge clk); #1;
    img_valid3 = 0;
    n = 0;
    while (!res_valid3 && n < 60) begin
      @(posedge clk); #1; n++;
    end
    checks++;
    if (n != NB + 3 || res_sum3 !== S'($countones(img))) begin
      errs++; $display("FAIL lat3 edges=%0d sum=%0d want %0d/%0d", n, res_sum3, NB + 3, $countones(img));
    end
    @(posedge clk); #1;
    res_ready3 = 0;
    checks++;
    if (res_valid3 !== 0 || img_ready3 !== 1) begin
      errs++; $display("FAIL lat3_hs rv=%b rdy=%b want 0/1", res_valid3, img_ready3);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 4; i++)
      run1(rnd_img(), int'($urandom_range(0, 5)), bit'($urandom_range(0, 1)), 0);
  endtask

`ifdef LGN_DRV_MAXTRACK_EN
  task automatic test_maxtrack();
    rst_n = 0; #1;
    checks++;
    if (max_sum !== '0 || max_idx !== '0) begin
      errs++; $display("FAIL max_reset sum=%0d idx=%0d want 0/0", max_sum, max_idx);
    end
    @(posedge clk); #1; rst_n = 1;
    run1(ones(100), 0, 0, 0);
    run1(ones(250), 0, 0, 0);
    run1(ones(250), 0, 0, 0);
    run1(ones(30), 0, 0, 0);
    checks++;
    if (max_sum !== S'(250) || max_idx !== 8'd1) begin
      errs++; $display("FAIL max_track sum=%0d idx=%0d want 250/1", max_sum, max_idx);
    end
    ovr_en = 1; ovr_val = S'(300);
    run1(ones(7), 0, 0, 1);
    ovr_en = 0;
    checks++;
    if (max_sum !== '0 || max_idx !== '0) begin
      errs++; $display("FAIL max_clr sum=%0d idx=%0d want 0/0", max_sum, max_idx);
    end
    run1(ones(5), 0, 0, 0);
    run1(ones(9), 0, 0, 0);
    checks++;
    if (max_sum !== S'(9) || max_idx !== 8'd1) begin
      errs++; $display("FAIL max_after_clr sum=%0d idx=%0d want 9/1", max_sum, max_idx);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_counting();
    test_all_ones_hold();
    test_ignore_valid();
    test_mid_reset();
    test_lat3();
    test_random();
`ifdef LGN_DRV_MAXTRACK_EN
    test_maxtrack();
`endif
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
